mem_bist_ctrl16_8: RTL

- Initiator/test master for the 16x8 memory unit: drives its rw/addr/data_in port and consumes data_out/data_valid.
- On a start pulse it writes a deterministic pattern to every address, then reads each address back and compares.
- Reports pass/fail, the error count and the first failing address.
- Used as built-in self-test beside the memory, and as the stimulus source in memory benches.

---
 rtl/mem_bist_ctrl16_8.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bist_ctrl16_8.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl16_8
//
// Built-in self-test master for the 16x8 memory unit. A start pulse accepted
// in IDLE launches one run:
//   WRITE : write pattern(a) = SEED + a to every address, 0 .. depth-1
//   READ  : read every address back, 0 .. depth-1
//   DRAIN : one extra cycle to compare the response to the last read
//   DONE  : single-cycle done pulse, pass/err_count/first_err_addr final
// Every read is compared one cycle after it is issued, against the pattern
// of the address it was issued for. A missing data-valid counts as an error.
//
// Optional feature (compile-time macro MEM_BIST_INV_PASS_EN):
//   When defined, DRAIN is followed by a second WRITE/READ/DRAIN pass using
//   the bit-inverted pattern ~pattern(a). Errors accumulate over both passes
//   and first_err_addr reports the earliest failure of either pass.
//   When undefined, only the single pass exists.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a run; sampled only in IDLE
//   mem_rw         out  0 = write, 1 = read
//   mem_addr       out  memory address (ADDR_W)
//   mem_wdata      out  memory write data (DATA_W)
//   mem_rdata      in   memory read data (DATA_W)
//   mem_rvalid     in   memory read data valid
//   busy           out  high from start acceptance through the drain cycle
//   done           out  single-cycle completion pulse
//   pass           out  1 = zero errors; set at completion, cleared on start
//   err_count      out  mismatch count of the current/last run (ADDR_W+2)
//   first_err_addr out  address of the first mismatch, 0 if none (ADDR_W)
// -----------------------------------------------------------------------------
module mem_bist_ctrl16_8 #(
  parameter int                 ADDR_W = 4,
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0]  SEED   = DATA_W'(8'hA5)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W+1:0]   err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
`ifdef MEM_BIST_INV_PASS_EN
    ST_WRITE_INV,
    ST_READ_INV,
    ST_DRAIN_INV,
`endif
    ST_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                exp_valid_q;
  logic [ADDR_W-1:0]   exp_addr_q;
  logic                exp_inv;

  logic [ADDR_W+1:0]   err_count_q;
  logic [ADDR_W+1:0]   err_count_d;
  logic [ADDR_W-1:0]   first_err_q;
  logic                pass_q;

  logic                accept;
  logic                addr_last;
  logic                is_write;
  logic                is_read;
  logic                write_inv;
  logic                read_inv;
  logic                final_drain;
  logic                err_now;
  logic [DATA_W-1:0]   exp_data;

  // Test pattern for address a; inv selects the bit-inverted variant.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic              inv);
    logic [DATA_W-1:0] p;
    p = SEED + DATA_W'(a);
    return inv ? ~p : p;
  endfunction

  // ---------------------------------------------------------------------------
  // State decode
  // ---------------------------------------------------------------------------
  assign accept    = (state_q == ST_IDLE) && start;
  assign addr_last = (addr_q == LAST_ADDR);

`ifdef MEM_BIST_INV_PASS_EN
  logic exp_inv_q;

  assign is_write    = (state_q == ST_WRITE) || (state_q == ST_WRITE_INV);
  assign is_read     = (state_q == ST_READ)  || (state_q == ST_READ_INV);
  assign write_inv   = (state_q == ST_WRITE_INV);
  assign read_inv    = (state_q == ST_READ_INV);
  assign final_drain = (state_q == ST_DRAIN_INV);
  assign exp_inv     = exp_inv_q;
`else
  assign is_write    = (state_q == ST_WRITE);
  assign is_read     = (state_q == ST_READ);
  assign write_inv   = 1'b0;
  assign read_inv    = 1'b0;
  assign final_drain = (state_q == ST_DRAIN);
  assign exp_inv     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start)     state_d = ST_WRITE;
      ST_WRITE:     if (addr_last) state_d = ST_READ;
      ST_READ:      if (addr_last) state_d = ST_DRAIN;
`ifdef MEM_BIST_INV_PASS_EN
      ST_DRAIN:                    state_d = ST_WRITE_INV;
      ST_WRITE_INV: if (addr_last) state_d = ST_READ_INV;
      ST_READ_INV:  if (addr_last) state_d = ST_DRAIN_INV;
      ST_DRAIN_INV:                state_d = ST_DONE;
`else
      ST_DRAIN:                    state_d = ST_DONE;
`endif
      ST_DONE:                     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rw = 1'b1;
    busy   = 1'b0;
    done   = 1'b0;
    if (is_write) begin
      mem_rw = 1'b0;
    end
    if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      busy = 1'b1;
    end
    if (state_q == ST_DONE) begin
      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Address and write-data generator. Write data is precomputed for the
  // address presented next, so the memory port is driven straight from flops.
  // The address only wraps when a write sweep hands over to its read sweep;
  // the read sweep leaves it parked on the last address through DRAIN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= '0;
      wdata_q <= pattern('0, 1'b0);
    end else if (is_write) begin
      if (addr_last) begin
        addr_q <= '0;
      end else begin
        addr_q  <= addr_q + 1'b1;
        wdata_q <= pattern(addr_q + 1'b1, write_inv);
      end
    end else if (is_read) begin
      if (!addr_last) begin
        addr_q <= addr_q + 1'b1;
      end
`ifdef MEM_BIST_INV_PASS_EN
    end else if (state_q == ST_DRAIN) begin
      addr_q  <= '0;
      wdata_q <= pattern('0, 1'b1);
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // ---------------------------------------------------------------------------
  // Read expectation pipeline: the memory answers one cycle after the read is
  // issued, so the issued address (and which pattern it belongs to) is delayed
  // by one stage to line up with the returning data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid_q <= 1'b0;
      exp_addr_q  <= '0;
`ifdef MEM_BIST_INV_PASS_EN
      exp_inv_q   <= 1'b0;
`endif
    end else begin
      exp_valid_q <= is_read;
      exp_addr_q  <= addr_q;
`ifdef MEM_BIST_INV_PASS_EN
      exp_inv_q   <= read_inv;
`endif
    end
  end

  // Compare: a missing valid is as much an error as wrong data.
  always_comb begin
    exp_data    = pattern(exp_addr_q, exp_inv);
    err_now     = exp_valid_q && (!mem_rvalid || (mem_rdata != exp_data));
    err_count_d = err_count_q;
    if (err_now) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers. pass is computed from the count including the final
  // compare in the drain cycle, so it is already valid while done is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else if (accept) begin
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      if (err_now && (err_count_q == '0)) begin
        first_err_q <= exp_addr_q;
      end
      if (final_drain) begin
        pass_q <= (err_count_d == '0);
      end
    end
  end

  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign pass           = pass_q;

endmodule
